// File: rtl/adder_sum_pipe_pkg.sv
// Shared widths and NZCV flag bit positions for the prefix-adder sum/flag pipeline.
package adder_sum_pipe_pkg;

    localparam int LEN_DATA = 32;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] nzcv_t;

    // Packs the four flags into their fixed bit positions.
    function automatic nzcv_t pack_nzcv(input logic n, input logic z, input logic c, input logic v);
        nzcv_t f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/adder_sum_flags.sv
// Combinational sum and NZCV from the final group-generate vector and half-sum vector.
module adder_sum_flags
    import adder_sum_pipe_pkg::*;
#(
    parameter int DW = LEN_DATA
) (
    input  logic [DW:0]   g_grp,
    input  logic [DW:0]   hsum,
    output logic [DW-1:0] sum,
    output nzcv_t         flags
);

    // Index 0 of hsum corresponds to the carry-in slot and has no sum bit.
    logic unused_hsum0;
    assign unused_hsum0 = hsum[0];

    // g_grp[k] is the carry into operand bit k.
    assign sum = hsum[DW:1] ^ g_grp[DW-1:0];

    assign flags = pack_nzcv(sum[DW-1],
                             (sum == '0),
                             g_grp[DW],
                             g_grp[DW-1] ^ g_grp[DW]);

endmodule

// File: rtl/adder_sum_pipe.sv
// Two-stage valid/ready pipeline turning prefix-tree carries into sum and NZCV flags.
module adder_sum_pipe
    import adder_sum_pipe_pkg::*;
#(
    parameter int DW    = LEN_DATA,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW:0]      g_grp,
    input  logic [DW:0]      hsum,
    input  logic             sub,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    sum,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_sub
);

    logic             vld_p0;
    logic [DW:0]      g_p0;
    logic [DW:0]      hsum_p0;
    logic             sub_p0;
    logic [TAG_W-1:0] tag_p0;

    logic             vld_p1;
    logic [DW-1:0]    sum_p1;
    nzcv_t            nzcv_p1;
    logic             sub_p1;
    logic [TAG_W-1:0] tag_p1;

    logic             a_load;
    logic             b_load;
    logic [DW-1:0]    sum_c;
    nzcv_t            nzcv_c;

    // Flush blocks acceptance so the dropped cycle cannot sneak an entry in.
    assign in_ready = !flush && (!vld_p0 || !vld_p1 || out_ready);
    assign a_load   = in_valid && in_ready;
    assign b_load   = vld_p0 && (!vld_p1 || out_ready);

    // Stage A: capture prefix-tree outputs
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_p0 <= 1'b0;
        end else if (a_load) begin
            vld_p0 <= 1'b1;
        end else if (b_load) begin
            vld_p0 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_p0    <= '0;
            hsum_p0 <= '0;
            sub_p0  <= 1'b0;
            tag_p0  <= '0;
        end else if (a_load) begin
            g_p0    <= g_grp;
            hsum_p0 <= hsum;
            sub_p0  <= sub;
            tag_p0  <= tag;
        end
    end

    adder_sum_flags #(
        .DW (DW)
    ) u_flags (
        .g_grp (g_p0),
        .hsum  (hsum_p0),
        .sum   (sum_c),
        .flags (nzcv_c)
    );

    // Stage B: registered result presented to the consumer
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_p1 <= 1'b0;
        end else if (b_load) begin
            vld_p1 <= 1'b1;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_p1  <= '0;
            nzcv_p1 <= '0;
            sub_p1  <= 1'b0;
            tag_p1  <= '0;
        end else if (b_load && !flush) begin
            sum_p1  <= sum_c;
            nzcv_p1 <= nzcv_c;
            sub_p1  <= sub_p0;
            tag_p1  <= tag_p0;
        end
    end

    assign out_valid = vld_p1;
    assign sum       = sum_p1;
    assign flag_n    = nzcv_p1[FLAG_N];
    assign flag_z    = nzcv_p1[FLAG_Z];
    assign flag_c    = nzcv_p1[FLAG_C];
    assign flag_v    = nzcv_p1[FLAG_V];
    assign out_tag   = tag_p1;
    assign out_sub   = sub_p1;

endmodule

// File: tb/tb_adder_sum_pipe.sv
// Randomized and directed bench for adder_sum_pipe against an a+b+cin scoreboard model.
module tb_adder_sum_pipe;
    import adder_sum_pipe_pkg::*;

    localparam int DW = LEN_DATA;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, sub, out_valid, out_ready;
    logic          flag_n, flag_z, flag_c, flag_v, out_sub;
    logic [DW:0]   g_grp, hsum;
    logic [TW-1:0] tag, out_tag;
    logic [DW-1:0] sum;

    logic [DW-1:0] cur_a, cur_b;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    logic          mon_en = 1'b0;

    typedef struct {
        logic [DW-1:0] sum;
        logic [3:0]    nzcv;
        logic [TW-1:0] tag;
        logic          sub;
        int            acc;
    } exp_t;

    exp_t sb[$];

    adder_sum_pipe #(.DW(DW), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .g_grp(g_grp), .hsum(hsum), .sub(sub), .tag(tag),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .out_tag(out_tag), .out_sub(out_sub)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Stimulus generator standing in for the upstream prefix tree.
    function automatic void make_gp(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s,
                                    output logic [DW:0] g, output logic [DW:0] h);
        logic [DW-1:0] bb;
        bb   = s ? ~b : b;
        g[0] = s;
        h[0] = 1'b0;
        for (int k = 0; k < DW; k++) begin
            h[k+1] = a[k] ^ bb[k];
            g[k+1] = (a[k] & bb[k]) | ((a[k] ^ bb[k]) & g[k]);
        end
    endfunction

    // Reference: plain wide arithmetic, returns {nzcv, sum}.
    function automatic logic [DW+3:0] ref_res(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s);
        logic [DW-1:0] bb;
        logic [DW:0]   r;
        logic          n, z, c, v;
        bb = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + {{DW{1'b0}}, s};
        n  = r[DW-1];
        z  = (r[DW-1:0] == '0);
        c  = r[DW];
        v  = (a[DW-1] == bb[DW-1]) && (r[DW-1] != a[DW-1]);
        return {n, z, c, v, r[DW-1:0]};
    endfunction

    task automatic set_in(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s, input logic [TW-1:0] t);
        logic [DW:0] g, h;
        make_gp(a, b, s, g, h);
        cur_a    = a;
        cur_b    = b;
        g_grp    = g;
        hsum     = h;
        sub      = s;
        tag      = t;
        in_valid = 1'b1;
    endtask

    // Scoreboard/compare process; entries live in the pipe for exactly two edges before showing.
    logic             stall_prev = 1'b0;
    logic [DW+5+TW:0] hold_val;
    always @(negedge clk) begin
        exp_t          e;
        logic          exp_ov, exp_rdy;
        logic [DW+3:0] m;
        if (mon_en) begin
            exp_ov  = (sb.size() > 0) && (cyc - sb[0].acc >= 2);
            exp_rdy = !flush && (sb.size() < 2 || out_ready);
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("out_valid", 64'(out_valid), 64'(exp_ov));
            if (exp_ov) begin
                chk("sum", 64'(sum), 64'(sb[0].sum));
                chk("nzcv", 64'({flag_n, flag_z, flag_c, flag_v}), 64'(sb[0].nzcv));
                chk("tag", 64'(out_tag), 64'(sb[0].tag));
                chk("sub", 64'(out_sub), 64'(sb[0].sub));
            end
            if (stall_prev)
                chk("hold", 64'({out_valid, sum, flag_n, flag_z, flag_c, flag_v, out_tag, out_sub}), 64'(hold_val));
            stall_prev = out_valid && !out_ready && !rst && !flush;
            hold_val   = {out_valid, sum, flag_n, flag_z, flag_c, flag_v, out_tag, out_sub};
            if (exp_ov && out_ready) void'(sb.pop_front());
            if (rst || flush) begin
                sb.delete();
            end else if (in_valid && exp_rdy) begin
                m      = ref_res(cur_a, cur_b, sub);
                e.sum  = m[DW-1:0];
                e.nzcv = m[DW+3:DW];
                e.tag  = tag;
                e.sub  = sub;
                e.acc  = cyc;
                sb.push_back(e);
            end
        end
    end

    task automatic single(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s,
                          input logic [TW-1:0] t, input logic [DW-1:0] es, input logic [3:0] ef);
        logic [DW+3:0] m;
        m = ref_res(a, b, s);
        chk("model_sum", 64'(m[DW-1:0]), 64'(es));
        chk("model_nzcv", 64'(m[DW+3:DW]), 64'(ef));
        @(posedge clk); #1;
        out_ready = 1'b1;
        set_in(a, b, s, t);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_early", 64'(out_valid), 64'(0));
        @(posedge clk);
        @(negedge clk);
        chk("lat2_valid", 64'(out_valid), 64'(1));
        chk("lit_sum", 64'(sum), 64'(es));
        chk("lit_nzcv", 64'({flag_n, flag_z, flag_c, flag_v}), 64'(ef));
        chk("lit_tag", 64'(out_tag), 64'(t));
        chk("lit_sub", 64'(out_sub), 64'(s));
        @(posedge clk); #1;
    endtask

    initial begin
        int   idx;
        logic saw_block;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sub = 1'b0; tag = '0; g_grp = '0; hsum = '0; cur_a = '0; cur_b = '0;
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(in_ready), 64'(1));
        chk("rst_payload", 64'({out_valid, sum, flag_n, flag_z, flag_c, flag_v, out_tag, out_sub}), 64'(0));

        single(32'd7, 32'd5, 1'b0, 4'h3, 32'd12, 4'b0000);
        single(32'h7FFF_FFFF, 32'd1, 1'b0, 4'h5, 32'h8000_0000, 4'b1001);
        single(32'hFFFF_FFFF, 32'd1, 1'b0, 4'h6, 32'h0000_0000, 4'b0110);
        single(32'd5, 32'd5, 1'b1, 4'h9, 32'h0000_0000, 4'b0110);
        single(32'd3, 32'd5, 1'b1, 4'hA, 32'hFFFF_FFFE, 4'b1000);

        // Back-to-back burst with the consumer stalled for four cycles.
        idx = 0; saw_block = 1'b0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            @(posedge clk); #1;
            out_ready = !(c >= 3 && c <= 6);
            set_in(32'(idx * 3 + 1), 32'(idx + 100), idx[0], TW'(idx));
            @(negedge clk);
            if (!in_ready) saw_block = 1'b1;
            else idx++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("b2b_sent", 64'(idx), 64'(8));
        chk("b2b_blocked", 64'(saw_block), 64'(1));
        chk("b2b_drained", 64'(sb.size()), 64'(0));

        // Flush with both stages full and a new input presented.
        @(posedge clk); #1;
        out_ready = 1'b0;
        set_in(32'd10, 32'd1, 1'b0, 4'h1);
        @(posedge clk); #1;
        set_in(32'd20, 32'd2, 1'b0, 4'h2);
        @(posedge clk); #1;
        set_in(32'd30, 32'd3, 1'b0, 4'h3);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_ready", 64'(in_ready), 64'(0));
        chk("flush_full", 64'(out_valid), 64'(1));
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", 64'(out_valid), 64'(0));
        single(32'd100, 32'd23, 1'b0, 4'h7, 32'd123, 4'b0000);

        // Reset while a result is stalled at the output.
        @(posedge clk); #1;
        out_ready = 1'b0;
        set_in(32'h1234_5678, 32'h1111_1111, 1'b0, 4'hF);
        @(posedge clk); #1;
        in_valid = 1'b0;
        idx = 0;
        while (!out_valid && idx < 10) begin
            @(posedge clk); #1;
            idx++;
        end
        chk("rst_stall_reached", 64'(out_valid), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_stall_held", 64'(sum), 64'(32'h2345_6789));
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_stall_out", 64'({out_valid, sum, flag_n, flag_z, flag_c, flag_v, out_tag, out_sub}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_stall_gone", 64'(out_valid), 64'(0));

        // Random traffic with random back-pressure and occasional flush.
        for (int c = 0; c < 13000; c++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) != 0)
                set_in($urandom(), $urandom(), $urandom_range(0, 1) == 1, TW'($urandom_range(0, 15)));
            else
                in_valid = 1'b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("final_drain", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
